// File: rtl/fpu_result_stage_pkg.sv
// rtl/fpu_result_stage_pkg.sv - shared FPU result types and flag bit positions
package fpu_result_stage_pkg;

    typedef struct packed {
        logic z;
        logic c;
        logic n;
        logic v;
    } condCode_t;

    typedef struct packed {
        logic invalid;
        logic divzero;
        logic overflow;
        logic underflow;
        logic inexact;
    } opStatusFlag_t;

    typedef struct packed {
        logic       sign;
        logic [4:0] exponent;
        logic [9:0] mantissa;
    } fp16_t;

    localparam int CC_W           = $bits(condCode_t);
    localparam int FLAG_W         = $bits(opStatusFlag_t);
    localparam int FLAG_INVALID   = 4;
    localparam int FLAG_DIVZERO   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

endpackage

// File: rtl/fpu_fifo2.sv
// rtl/fpu_fifo2.sv - two-entry registered FIFO with flush
module fpu_fifo2 #(
    parameter int W = 25
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push_valid,
    output logic         push_ready,
    input  logic [W-1:0] push_data,
    output logic         pop_valid,
    input  logic         pop_ready,
    output logic [W-1:0] pop_data,
    output logic [1:0]   count,
    output logic         push_fire,
    output logic         pop_fire
);

    logic [W-1:0] mem0_q, mem0_d;
    logic [W-1:0] mem1_q, mem1_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;

    always_comb begin
        push_ready = (count_q != 2'd2);
        pop_valid  = (count_q != 2'd0);
        push_fire  = push_valid && push_ready && !flush;
        pop_fire   = pop_valid && pop_ready && !flush;
        // Head reads as zero when empty so stale entries never leak out.
        pop_data   = '0;
        if (pop_valid) begin
            pop_data = rd_ptr_q ? mem1_q : mem0_q;
        end

        mem0_d   = mem0_q;
        mem1_d   = mem1_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push_fire) begin
                if (wr_ptr_q) begin
                    mem1_d = push_data;
                end else begin
                    mem0_d = push_data;
                end
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop_fire) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push_fire, pop_fire})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem0_q   <= '0;
            mem1_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem0_q   <= mem0_d;
            mem1_q   <= mem1_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fpu_result_stage.sv
// rtl/fpu_result_stage.sv - buffers add/sub results and accumulates sticky IEEE flags
module fpu_result_stage
    import fpu_result_stage_pkg::*;
#(
    parameter type FP_T = fp16_t,
    parameter int  FPW  = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [FPW-1:0] in_result,
    input  logic [3:0]     in_cc,
    input  logic [4:0]     in_flags,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [FPW-1:0] out_result,
    output logic [3:0]     out_cc,
    output logic [4:0]     out_flags,
    output logic [4:0]     acc_flags,
    input  logic           clear_flags,
    input  logic           flush,
    output logic [1:0]     count,
    output logic [15:0]    pop_count
);

    localparam int PW = FPW + CC_W + FLAG_W;

    logic [PW-1:0] head_data;
    logic          push_fire;
    logic          pop_fire;
    FP_T           head_result;
    condCode_t     head_cc;
    opStatusFlag_t head_flags;
    opStatusFlag_t acc_flags_q, acc_flags_d;
    logic [15:0]   pop_count_q, pop_count_d;

    fpu_fifo2 #(
        .W(PW)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .push_valid (in_valid),
        .push_ready (in_ready),
        .push_data  ({in_result, in_cc, in_flags}),
        .pop_valid  (out_valid),
        .pop_ready  (out_ready),
        .pop_data   (head_data),
        .count      (count),
        .push_fire  (push_fire),
        .pop_fire   (pop_fire)
    );

    assign head_result = FP_T'(head_data[PW-1 -: FPW]);
    assign head_cc     = condCode_t'(head_data[FLAG_W +: CC_W]);
    assign head_flags  = opStatusFlag_t'(head_data[FLAG_W-1:0]);
    assign out_result  = FPW'(head_result);
    assign out_cc      = head_cc;
    assign out_flags   = head_flags;

    // Clear is applied first so a same-cycle push still records its flags.
    always_comb begin
        acc_flags_d = acc_flags_q;
        if (clear_flags) begin
            acc_flags_d = '0;
        end
        if (push_fire) begin
            acc_flags_d = acc_flags_d | opStatusFlag_t'(in_flags);
        end
        pop_count_d = pop_count_q;
        if (pop_fire) begin
            pop_count_d = pop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_flags_q <= '0;
            pop_count_q <= 16'd0;
        end else begin
            acc_flags_q <= acc_flags_d;
            pop_count_q <= pop_count_d;
        end
    end

    assign acc_flags = acc_flags_q;
    assign pop_count = pop_count_q;

endmodule

// File: tb/tb_fpu_result_stage.sv
// tb/tb_fpu_result_stage.sv - scoreboard bench for fpu_result_stage
module tb_fpu_result_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_result;
    logic [3:0]  in_cc;
    logic [4:0]  in_flags;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [3:0]  out_cc;
    logic [4:0]  out_flags;
    logic [4:0]  acc_flags;
    logic        clear_flags;
    logic        flush;
    logic [1:0]  count;
    logic [15:0] pop_count;

    logic [24:0] sb[$];
    logic [4:0]  m_acc;
    logic [15:0] m_pop;
    logic [4:0]  saved_acc;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    fpu_result_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_result   (in_result),
        .in_cc       (in_cc),
        .in_flags    (in_flags),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_cc      (out_cc),
        .out_flags   (out_flags),
        .acc_flags   (acc_flags),
        .clear_flags (clear_flags),
        .flush       (flush),
        .count       (count),
        .pop_count   (pop_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] res, input logic [3:0] cc,
                         input logic [4:0] fl, input logic ordy);
        in_valid  = v;
        in_result = res;
        in_cc     = cc;
        in_flags  = fl;
        out_ready = ordy;
    endtask

    // Check outputs against the model mid-cycle, update the model, then clock.
    task automatic cyc();
        logic push;
        logic pop;
        check("in_ready", 32'(in_ready), 32'(sb.size() != 2));
        check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        check("count", 32'(count), 32'(sb.size()));
        check("acc_flags", 32'(acc_flags), 32'(m_acc));
        check("pop_count", 32'(pop_count), 32'(m_pop));
        if (sb.size() != 0) begin
            check("head", 32'({out_result, out_cc, out_flags}), 32'(sb[0]));
        end else begin
            check("empty_zero", 32'({out_result, out_cc, out_flags}), 32'd0);
        end
        push = in_valid && (sb.size() != 2) && !flush;
        pop  = out_ready && (sb.size() != 0) && !flush;
        if (clear_flags) m_acc = 5'd0;
        if (push) m_acc = m_acc | in_flags;
        if (flush) begin
            sb.delete();
        end else begin
            if (pop) begin
                void'(sb.pop_front());
                m_pop = m_pop + 16'd1;
            end
            if (push) sb.push_back({in_result, in_cc, in_flags});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst_n       = 1'b0;
        clear_flags = 1'b0;
        flush       = 1'b0;
        drive(1'b0, 16'h0, 4'h0, 5'h0, 1'b0);
        m_acc = 5'd0;
        m_pop = 16'd0;
        #2;
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_fields", 32'({out_result, out_cc, out_flags, acc_flags}), 32'd0);
        check("rst_pop_count", 32'(pop_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single 1.0 through an empty stage
        drive(1'b1, 16'h3C00, 4'b0000, 5'b00000, 1'b1);
        cyc();
        in_valid = 1'b0;
        check("t038_out_valid", 32'(out_valid), 32'd1);
        check("t038_result", 32'(out_result), 32'h3C00);
        cyc();
        check("t038_count", 32'(count), 32'd0);
        check("t038_pop_count", 32'(pop_count), 32'd1);

        // Backpressure: fill, reject third, drain in order
        drive(1'b1, 16'h4000, 4'b0001, 5'b00000, 1'b0);
        cyc();
        in_result = 16'h4200;
        cyc();
        check("t039_in_ready", 32'(in_ready), 32'd0);
        in_result = 16'h4400;
        cyc();
        drive(1'b0, 16'h0, 4'h0, 5'h0, 1'b1);
        check("t039_first", 32'(out_result), 32'h4000);
        cyc();
        check("t039_second", 32'(out_result), 32'h4200);
        cyc();
        cyc();

        // Full with push+pop: pop only
        drive(1'b1, 16'h4500, 4'b0010, 5'b00000, 1'b0);
        cyc();
        in_result = 16'h4600;
        cyc();
        drive(1'b1, 16'h4700, 4'b0011, 5'b00000, 1'b1);
        cyc();
        check("t040_count", 32'(count), 32'd1);
        // Count 1 with push+pop: steady, pointers wrap
        for (int i = 0; i < 5; i++) begin
            in_result = 16'h4800 + 16'(i);
            cyc();
            check("t041_count", 32'(count), 32'd1);
        end
        in_valid = 1'b0;
        cyc();
        cyc();

        // Sticky flags and clear-before-OR
        drive(1'b1, 16'h3800, 4'b0000, 5'b00001, 1'b1);
        cyc();
        in_flags = 5'b00100;
        cyc();
        in_valid = 1'b0;
        cyc();
        check("t042_acc", 32'(acc_flags), 32'h05);
        clear_flags = 1'b1;
        drive(1'b1, 16'h3900, 4'b0100, 5'b10000, 1'b1);
        cyc();
        clear_flags = 1'b0;
        in_valid    = 1'b0;
        cyc();
        check("t042_clear", 32'(acc_flags), 32'h10);

        // Flush with two queued and a concurrent push
        drive(1'b1, 16'h5000, 4'b1000, 5'b01000, 1'b0);
        cyc();
        in_result = 16'h5100;
        cyc();
        saved_acc = m_acc;
        in_flags  = 5'b00010;
        flush     = 1'b1;
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("t043_count", 32'(count), 32'd0);
        check("t043_out_valid", 32'(out_valid), 32'd0);
        check("t043_acc", 32'(acc_flags), 32'(saved_acc));
        cyc();

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 16'($urandom), 4'($urandom), 5'($urandom),
                  1'($urandom_range(0, 1)));
            flush       = ($urandom_range(0, 15) == 0);
            clear_flags = ($urandom_range(0, 15) == 0);
            cyc();
        end
        flush       = 1'b0;
        clear_flags = 1'b0;

        // Stream until pop_count reaches FFFF, then one more pop wraps it
        drive(1'b1, 16'h3C01, 4'b0101, 5'b00000, 1'b1);
        n = 0;
        while (m_pop != 16'hFFFF && n < 70000) begin
            cyc();
            n++;
        end
        check("t045_max", 32'(pop_count), 32'hFFFF);
        in_valid = 1'b0;
        cyc();
        check("t045_wrap", 32'(pop_count), 32'h0);

        // Asynchronous reset mid-stream
        drive(1'b1, 16'h6000, 4'b1111, 5'b11111, 1'b0);
        cyc();
        in_result = 16'h6100;
        cyc();
        rst_n = 1'b0;
        drive(1'b0, 16'h0, 4'h0, 5'h0, 1'b0);
        #1;
        check("t044_count", 32'(count), 32'd0);
        check("t044_out_valid", 32'(out_valid), 32'd0);
        check("t044_fields", 32'({out_result, out_cc, out_flags}), 32'd0);
        check("t044_acc", 32'(acc_flags), 32'd0);
        check("t044_pop", 32'(pop_count), 32'd0);
        check("t044_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        m_acc = 5'd0;
        m_pop = 16'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 16'h7000, 4'b0110, 5'b00010, 1'b1);
        cyc();
        in_valid = 1'b0;
        check("t035_first", 32'(out_result), 32'h7000);
        cyc();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpu_result_stage.md
FPU_RESULT_STAGE -- requirements
Module: fpu_result_stage

Interface
REQ-001 Parameter FP_T, default fp16_t: result format carried through the stage.
REQ-002 Parameter FPW, default 16: bit width of FP_T.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  upstream fpuAddSub result is valid this cycle.
REQ-006 in_ready  output  1  stage accepts a result this cycle.
REQ-007 in_result  input  FPW  fpuOut from the add/sub datapath.
REQ-008 in_cc  input  4  condCode_t {Z,C,N,V} from the datapath.
REQ-009 in_flags  input  5  opStatusFlag_t {invalid, divzero, overflow, underflow, inexact}.
REQ-010 out_valid  output  1  head entry is presented.
REQ-011 out_ready  input  1  consumer takes the head entry.
REQ-012 out_result, out_cc, out_flags  output  FPW/4/5  head entry fields.
REQ-013 acc_flags  output  5  IEEE sticky exception flags.
REQ-014 clear_flags  input  1  clears acc_flags.
REQ-015 flush  input  1  discards all queued entries.
REQ-016 count  output  2  occupancy, 0..2.
REQ-017 pop_count  output  16  number of entries delivered, wrapping.

Function
REQ-018 Storage SHALL be a 2-entry FIFO with 1-bit read/write pointers and a registered count.
REQ-019 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-020 in_ready SHALL be (count != 2), independent of out_ready; no push when full, even with a concurrent pop.
REQ-021 out_valid SHALL be (count != 0); out_* SHALL be driven from the head entry register, with zero combinational path from in_* to out_*.
REQ-022 Latency SHALL be 1 cycle: a push into an empty stage gives out_valid=1 on the next cycle.
REQ-023 Push and pop in the same cycle SHALL leave count unchanged, with both pointers advancing.
REQ-024 Pointers SHALL wrap from 1 to 0.
REQ-025 out_* SHALL hold stable while out_valid && !out_ready.
REQ-026 On an accepted push, acc_flags SHALL become acc_flags | in_flags on the next cycle.
REQ-027 clear_flags and a push in the same cycle SHALL give acc_flags = in_flags, i.e. clear applied before the OR.
REQ-028 flush SHALL set count and both pointers to 0 next cycle and override any same-cycle push or pop.
REQ-029 flush SHALL NOT alter acc_flags or pop_count.
REQ-030 pop_count SHALL increment by 1 per pop, wrapping 16'hFFFF to 0.
REQ-031 When out_valid=0, out_result/out_cc/out_flags SHALL read 0.

Reset
REQ-032 While rst_n=0, the following SHALL be 0 asynchronously: count, pointers, acc_flags, pop_count, out_valid, out_* fields.
REQ-033 While rst_n=0, in_ready SHALL be 1.
REQ-034 Reset during a pending transfer SHALL drop all entries, with no partial update after deassertion.
REQ-035 The first push SHALL be accepted on the first rising edge after rst_n rises.

Structure
REQ-036 condCode_t, opStatusFlag_t, fp16_t and the flag bit-position constants SHALL come from the shared FPU package/constants file and SHALL NOT be redeclared here.
REQ-037 The FIFO SHALL be one sub-module, fpu_fifo2, parameterised by payload width; sticky flags and pop_count SHALL live in the top module.

Verification
REQ-038 Reset, then push 16'h3C00 (1.0), cc 4'b0000, flags 0 with out_ready=1 -> next cycle out_valid=1, out_result=16'h3C00; following cycle count=0, pop_count=1.
REQ-039 out_ready=0; push 16'h4000 then 16'h4200 -> in_ready=0 when count=2; a third in_valid is not accepted; release out_ready -> outputs 4000 then 4200, in order.
REQ-040 Full FIFO with push and pop asserted in the same cycle -> no push, count goes 2->1.
REQ-041 Count=1 with push and pop in the same cycle -> count stays 1, pointers wrap correctly.
REQ-042 Push flags 5'b00001, then 5'b00100 -> acc_flags=5'b00101; assert clear_flags with push flags 5'b10000 -> acc_flags=5'b10000.
REQ-043 Two entries queued, flush with in_valid=1 -> count=0, out_valid=0, acc_flags unchanged.
REQ-044 Assert rst_n=0 mid-stream -> all outputs 0 without a clock edge.
REQ-045 Hold pop_count at 16'hFFFF, then pop once -> pop_count=0.
